// File: rtl/inst_decode_stage_pkg.sv
// Shared types for the decode stage: opcodes, decode flags, decoded entry and buffer state.
package inst_decode_stage_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_OP     = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } OpCode;

    typedef struct packed {
        logic illegal;
        logic alu;
        logic ecall;
        logic ebreak;
        logic wfi;
        logic mret;
        logic csr;
        logic fence;
        logic fencei;
    } DecFlags;

    // Register fields are kept at full 5-bit width; the stage trims them on output.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        OpCode       op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] csr;
        logic [31:0] imm;
        DecFlags     flags;
    } DecodedInst;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } BufState;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] INST_WFI    = 32'h1050_0073;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface inst_decode_stage_if
    import inst_decode_stage_pkg::*;
#(
    parameter int REG_WIDTH = 5
);
    logic                 i_flush;
    logic                 i_valid;
    logic                 o_ready;
    logic [31:0]          i_inst;
    logic [31:0]          i_pc;
    logic                 o_valid;
    logic                 i_ready;
    logic [31:0]          o_pc;
    logic [31:0]          o_inst;
    OpCode                o_op;
    logic [REG_WIDTH-1:0] o_rs1;
    logic [REG_WIDTH-1:0] o_rs2;
    logic [REG_WIDTH-1:0] o_rd;
    logic [11:0]          o_csr;
    logic [31:0]          o_imm;
    DecFlags              o_flags;

    // Surrounding pipeline: supplies instructions and downstream ready.
    modport master (
        output i_flush, i_valid, i_inst, i_pc, i_ready,
        input  o_ready, o_valid, o_pc, o_inst, o_op, o_rs1, o_rs2, o_rd,
               o_csr, o_imm, o_flags
    );

    // Decode stage itself.
    modport slave (
        input  i_flush, i_valid, i_inst, i_pc, i_ready,
        output o_ready, o_valid, o_pc, o_inst, o_op, o_rs1, o_rs2, o_rd,
               o_csr, o_imm, o_flags
    );
endinterface

// File: rtl/inst_decode_stage_comb.sv
// Pure combinational RV32I/E decoder: instruction word -> DecodedInst.
module inst_decode_comb
    import inst_decode_stage_pkg::*;
#(
    parameter int REG_WIDTH       = 5,
    parameter bit RV_EXT_M        = 1'b1,
    parameter bit RV_EXT_Zicsr    = 1'b1,
    parameter bit RV_EXT_Zifencei = 1'b1
) (
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output DecodedInst  dec
);
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        legal;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    DecFlags     flags;
    logic [31:0] imm;

    assign funct7 = inst[31:25];
    assign funct3 = inst[14:12];

    // Classify the word, pick its immediate and note which register fields it really uses.
    always_comb begin
        legal   = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        flags   = '0;
        imm     = '0;
        dec     = '0;
        case (inst[6:0])
            OP_LUI, OP_AUIPC: begin
                legal  = 1'b1;
                use_rd = 1'b1;
                imm    = imm_u(inst);
            end
            OP_JAL: begin
                legal  = 1'b1;
                use_rd = 1'b1;
                imm    = imm_j(inst);
            end
            OP_JALR: begin
                legal   = (funct3 == 3'b000);
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm     = imm_i(inst);
            end
            OP_BRANCH: begin
                legal   = (funct3 != 3'b010) && (funct3 != 3'b011);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = imm_b(inst);
            end
            OP_LOAD: begin
                legal   = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                imm     = imm_i(inst);
            end
            OP_STORE: begin
                legal   = funct3 inside {3'b000, 3'b001, 3'b010};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = imm_s(inst);
            end
            OP_IMM: begin
                use_rd    = 1'b1;
                use_rs1   = 1'b1;
                flags.alu = 1'b1;
                case (funct3)
                    3'b001: begin
                        legal = (funct7 == F7_BASE);
                        imm   = {27'b0, inst[24:20]};
                    end
                    3'b101: begin
                        legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        imm   = {27'b0, inst[24:20]};
                    end
                    default: begin
                        legal = 1'b1;
                        imm   = imm_i(inst);
                    end
                endcase
            end
            OP_OP: begin
                use_rd    = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                flags.alu = 1'b1;
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                end else if (funct7 == F7_ALT) begin
                    legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                end else if (funct7 == F7_MUL) begin
                    legal = RV_EXT_M;
                end
            end
            OP_FENCE: begin
                if (funct3 == 3'b000) begin
                    legal       = 1'b1;
                    flags.fence = 1'b1;
                end else if (funct3 == 3'b001) begin
                    legal        = RV_EXT_Zifencei;
                    flags.fencei = 1'b1;
                end
            end
            OP_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    // Privileged/environment ops only at their exact encodings.
                    case (inst)
                        INST_ECALL:  begin legal = 1'b1; flags.ecall  = 1'b1; end
                        INST_EBREAK: begin legal = 1'b1; flags.ebreak = 1'b1; end
                        INST_MRET:   begin legal = 1'b1; flags.mret   = 1'b1; end
                        INST_WFI:    begin legal = 1'b1; flags.wfi    = 1'b1; end
                        default:     legal = 1'b0;
                    endcase
                end else if (funct3 != 3'b100) begin
                    legal     = RV_EXT_Zicsr;
                    flags.csr = 1'b1;
                    use_rd    = 1'b1;
                    if (funct3[2]) begin
                        imm = {27'b0, inst[19:15]};
                    end else begin
                        use_rs1 = 1'b1;
                    end
                end
            end
            default: legal = 1'b0;
        endcase

        // With a 16-entry register file any used field reaching x16..x31 is illegal.
        if (REG_WIDTH < 5) begin
            if ((use_rd && inst[11]) || (use_rs1 && inst[19]) || (use_rs2 && inst[24])) begin
                legal = 1'b0;
            end
        end

        if (!legal) begin
            flags         = '0;
            flags.illegal = 1'b1;
            imm           = '0;
        end

        dec.pc    = pc;
        dec.inst  = inst;
        dec.op    = OpCode'(inst[6:0]);
        dec.rs1   = inst[19:15];
        dec.rs2   = inst[24:20];
        dec.rd    = inst[11:7];
        dec.csr   = inst[31:20];
        dec.imm   = imm;
        dec.flags = flags;
    end
endmodule

// File: rtl/inst_decode_stage.sv
// Decode pipeline stage: decodes on the input side and buffers results in a 2-entry skid buffer.
module inst_decode_stage
    import inst_decode_stage_pkg::*;
#(
    parameter int REG_WIDTH       = 5,
    parameter bit RV_EXT_M        = 1'b1,
    parameter bit RV_EXT_Zicsr    = 1'b1,
    parameter bit RV_EXT_Zifencei = 1'b1
) (
    input logic                i_clock,
    input logic                i_reset,
    inst_decode_stage_if.slave bus
);
    DecodedInst dec_in;
    DecodedInst out_q;
    DecodedInst skid_q;
    BufState    state;
    logic       valid_q;
    logic       ready_q;
    logic       take_in;
    logic       take_out;

    inst_decode_comb #(
        .REG_WIDTH       (REG_WIDTH),
        .RV_EXT_M        (RV_EXT_M),
        .RV_EXT_Zicsr    (RV_EXT_Zicsr),
        .RV_EXT_Zifencei (RV_EXT_Zifencei)
    ) u_comb (
        .inst (bus.i_inst),
        .pc   (bus.i_pc),
        .dec  (dec_in)
    );

    assign take_in  = bus.i_valid & ready_q;
    assign take_out = valid_q & bus.i_ready;

    // Skid-buffer FSM; valid/ready are registered from the next state, data loads only on transfer.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else if (bus.i_flush) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (take_in) begin
                        out_q   <= dec_in;
                        state   <= ST_ONE;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (take_in && !take_out) begin
                        skid_q  <= dec_in;
                        state   <= ST_TWO;
                        valid_q <= 1'b1;
                        ready_q <= 1'b0;
                    end else if (take_out && !take_in) begin
                        state   <= ST_EMPTY;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (take_in && take_out) begin
                        out_q   <= dec_in;
                    end
                end
                ST_TWO: begin
                    if (take_out) begin
                        out_q   <= skid_q;
                        state   <= ST_ONE;
                        valid_q <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_pc    = out_q.pc;
    assign bus.o_inst  = out_q.inst;
    assign bus.o_op    = out_q.op;
    assign bus.o_rs1   = out_q.rs1[REG_WIDTH-1:0];
    assign bus.o_rs2   = out_q.rs2[REG_WIDTH-1:0];
    assign bus.o_rd    = out_q.rd[REG_WIDTH-1:0];
    assign bus.o_csr   = out_q.csr;
    assign bus.o_imm   = out_q.imm;
    assign bus.o_flags = out_q.flags;
endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench: RV32I/M stage and RV32E/no-M stage driven in lockstep, scoreboarded per stage.
module tb_inst_decode_stage;
    import inst_decode_stage_pkg::*;

    localparam logic [8:0] F_NONE   = 9'h000;
    localparam logic [8:0] F_ILL    = 9'h100;
    localparam logic [8:0] F_ALU    = 9'h080;
    localparam logic [8:0] F_ECALL  = 9'h040;
    localparam logic [8:0] F_EBREAK = 9'h020;
    localparam logic [8:0] F_WFI    = 9'h010;
    localparam logic [8:0] F_MRET   = 9'h008;
    localparam logic [8:0] F_CSR    = 9'h004;
    localparam logic [8:0] F_FENCE  = 9'h002;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] imm;
        logic [8:0]  flags;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] pc_n;
    exp_t q_main[$];
    exp_t q_e[$];

    inst_decode_stage_if #(.REG_WIDTH(5)) bus ();
    inst_decode_stage_if #(.REG_WIDTH(4)) bus_e ();

    assign bus_e.i_flush = bus.i_flush;
    assign bus_e.i_valid = bus.i_valid;
    assign bus_e.i_inst  = bus.i_inst;
    assign bus_e.i_pc    = bus.i_pc;
    assign bus_e.i_ready = bus.i_ready;

    inst_decode_stage #(
        .REG_WIDTH(5), .RV_EXT_M(1'b1), .RV_EXT_Zicsr(1'b1), .RV_EXT_Zifencei(1'b1)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    inst_decode_stage #(
        .REG_WIDTH(4), .RV_EXT_M(1'b0), .RV_EXT_Zicsr(1'b1), .RV_EXT_Zifencei(1'b1)
    ) dut_e (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one word (pc auto-increments), push both expectations, wait for acceptance.
    task automatic go(input logic [31:0] inst,
                      input logic [31:0] imm_m, input logic [8:0] fl_m,
                      input logic [31:0] imm_e, input logic [8:0] fl_e);
        exp_t em;
        exp_t ee;
        bit   acc;
        int   n;
        pc_n = pc_n + 32'd4;
        bus.i_valid = 1'b1;
        bus.i_inst  = inst;
        bus.i_pc    = pc_n;
        em.pc = pc_n; em.inst = inst; em.imm = imm_m; em.flags = fl_m;
        ee.pc = pc_n; ee.inst = inst; ee.imm = imm_e; ee.flags = fl_e;
        q_main.push_back(em);
        q_e.push_back(ee);
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.o_ready;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        assert (acc) else begin
            failures++;
            $error("FAIL accept_timeout: observed=no accept expected=accept pc=%h", pc_n);
        end
    endtask

    task automatic idle(input int cycles);
        bus.i_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: compare every downstream transfer of both stages against the queued expectations.
    always @(negedge clk) begin
        exp_t em;
        exp_t ee;
        if (!rst && !bus.i_flush && bus.o_valid && bus.i_ready) begin
            checks++;
            assert (q_main.size() > 0 && q_e.size() > 0) else begin
                failures++;
                $error("FAIL sb_underflow: observed pc=%h expected=no output", bus.o_pc);
            end
            if (q_main.size() > 0 && q_e.size() > 0) begin
                em = q_main.pop_front();
                ee = q_e.pop_front();
                check($sformatf("pc@%h", em.pc), bus.o_pc, em.pc);
                check($sformatf("inst@%h", em.pc), bus.o_inst, em.inst);
                check($sformatf("imm@%h", em.pc), bus.o_imm, em.imm);
                check($sformatf("flags@%h", em.pc), 32'(bus.o_flags), 32'(em.flags));
                check($sformatf("e_valid@%h", ee.pc), 32'(bus_e.o_valid), 32'd1);
                check($sformatf("e_pc@%h", ee.pc), bus_e.o_pc, ee.pc);
                check($sformatf("e_inst@%h", ee.pc), bus_e.o_inst, ee.inst);
                check($sformatf("e_imm@%h", ee.pc), bus_e.o_imm, ee.imm);
                check($sformatf("e_flags@%h", ee.pc), 32'(bus_e.o_flags), 32'(ee.flags));
            end
        end
    end

    initial begin
        logic [31:0] pc_a;
        bit          acc;
        int          n;
        checks        = 0;
        failures      = 0;
        pc_n          = 32'h0000_1000;
        rst           = 1'b1;
        bus.i_flush   = 1'b0;
        bus.i_valid   = 1'b0;
        bus.i_inst    = '0;
        bus.i_pc      = '0;
        bus.i_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_pc", bus.o_pc, 32'd0);
        check("rst_inst", bus.o_inst, 32'd0);
        check("rst_imm", bus.o_imm, 32'd0);
        check("rst_flags", 32'(bus.o_flags), 32'd0);
        check("rst_e_ready", 32'(bus_e.o_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back stream, downstream always ready
        bus.i_ready = 1'b1;
        go(32'h0050_0093, 32'd5, F_ALU, 32'd5, F_ALU);          // ADDI x1,x0,5
        check("lat1_valid", 32'(bus.o_valid), 32'd1);
        check("lat1_pc", bus.o_pc, pc_n);
        go(32'h0020_81B3, 32'd0, F_ALU, 32'd0, F_ALU);          // ADD x3,x1,x2
        check("nobubble_valid", 32'(bus.o_valid), 32'd1);
        check("nobubble_pc", bus.o_pc, pc_n);
        go(32'h0220_8033, 32'd0, F_ALU, 32'd0, F_ILL);          // MUL: no M on RV32E stage
        go(32'h0020_8833, 32'd0, F_ALU, 32'd0, F_ILL);          // ADD x16: illegal on RV32E
        check("rd16_main", 32'(bus.o_rd), 32'd16);
        go(32'h0020_87B3, 32'd0, F_ALU, 32'd0, F_ALU);          // ADD x15
        go(32'h4030_D093, 32'd3, F_ALU, 32'd3, F_ALU);          // SRAI x1,x1,3
        go(32'h1234_52B7, 32'h1234_5000, F_NONE, 32'h1234_5000, F_NONE); // LUI x5
        go(32'hFE20_8EE3, 32'hFFFF_FFFC, F_NONE, 32'hFFFF_FFFC, F_NONE); // BEQ -4
        go(32'h0020_A423, 32'd8, F_NONE, 32'd8, F_NONE);        // SW x2,8(x1)
        go(32'h3002_D0F3, 32'd5, F_CSR, 32'd5, F_CSR);          // CSRRWI x1,0x300,5
        check("csr_field", 32'(bus.o_csr), 32'h300);
        go(32'h0FF0_000F, 32'd0, F_FENCE, 32'd0, F_FENCE);      // FENCE
        go(32'h0010_0073, 32'd0, F_EBREAK, 32'd0, F_EBREAK);
        go(32'h0000_0073, 32'd0, F_ECALL, 32'd0, F_ECALL);
        go(32'h3020_0073, 32'd0, F_MRET, 32'd0, F_MRET);
        go(32'h1050_0073, 32'd0, F_WFI, 32'd0, F_WFI);
        go(32'hFFFF_FFFF, 32'd0, F_ILL, 32'd0, F_ILL);          // unknown opcode
        go(32'h0000_2063, 32'd0, F_ILL, 32'd0, F_ILL);          // branch funct3=010
        idle(3);
        check("stream_drained", 32'(q_main.size()), 32'd0);

        // Backpressure: two accepted, third held until release
        bus.i_ready = 1'b0;
        go(32'h0010_0093, 32'd1, F_ALU, 32'd1, F_ALU);
        pc_a = pc_n;
        check("hold_ready_one", 32'(bus.o_ready), 32'd1);
        go(32'h0020_0093, 32'd2, F_ALU, 32'd2, F_ALU);
        check("hold_ready_two", 32'(bus.o_ready), 32'd0);
        pc_n = pc_n + 32'd4;
        bus.i_valid = 1'b1;
        bus.i_inst  = 32'h0030_0093;
        bus.i_pc    = pc_n;
        q_main.push_back('{pc: pc_n, inst: 32'h0030_0093, imm: 32'd3, flags: F_ALU});
        q_e.push_back('{pc: pc_n, inst: 32'h0030_0093, imm: 32'd3, flags: F_ALU});
        repeat (2) @(posedge clk);
        #1;
        check("hold_ready_stuck", 32'(bus.o_ready), 32'd0);
        check("hold_valid", 32'(bus.o_valid), 32'd1);
        check("hold_pc_stable", bus.o_pc, pc_a);
        check("hold_imm_stable", bus.o_imm, 32'd1);
        bus.i_ready = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.o_ready;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        assert (acc) else begin
            failures++;
            $error("FAIL hold_accept_timeout: observed=no accept expected=accept");
        end
        idle(4);
        check("hold_drained", 32'(q_main.size()), 32'd0);

        // Flush while full with a word on offer
        bus.i_ready = 1'b0;
        go(32'h0040_0093, 32'd4, F_ALU, 32'd4, F_ALU);
        go(32'h0050_0093, 32'd5, F_ALU, 32'd5, F_ALU);
        check("flush_pre_ready", 32'(bus.o_ready), 32'd0);
        bus.i_valid = 1'b1;
        bus.i_inst  = 32'h0060_0093;
        bus.i_pc    = 32'hDEAD_0000;
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        check("flush_valid", 32'(bus.o_valid), 32'd0);
        check("flush_ready", 32'(bus.o_ready), 32'd1);
        check("flush_e_valid", 32'(bus_e.o_valid), 32'd0);
        q_main.delete();
        q_e.delete();
        bus.i_ready = 1'b1;
        idle(3);
        check("flush_quiet", 32'(bus.o_valid), 32'd0);
        go(32'h0070_0093, 32'd7, F_ALU, 32'd7, F_ALU);
        idle(3);
        check("flush_recover_drained", 32'(q_main.size()), 32'd0);

        // Mid-stream reset drops the buffered entry and clears data
        bus.i_ready = 1'b0;
        go(32'h0080_0093, 32'd8, F_ALU, 32'd8, F_ALU);
        bus.i_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_main.delete();
        q_e.delete();
        check("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.o_ready), 32'd1);
        check("mid_rst_pc", bus.o_pc, 32'd0);
        check("mid_rst_imm", bus.o_imm, 32'd0);
        bus.i_ready = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
